cp0_intc: RTL

CP0_INTC -- requirements
Module: cp0_intc

---
 rtl/cp0_intc.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/cp0_intc.sv
// cp0_intc: a small interrupt controller in the style of MIPS coprocessor 0.
// It holds the IE, MASK, EPC, PEND and CAUSE registers, picks the
// highest-priority pending interrupt (lowest index wins), raises a request to
// the core and records the return PC when the core acknowledges the request.
//
// Ports:
//   in_CLK, in_RST_N    clock (rising edge) and asynchronous active-low reset
//   WE, rW, W           software register write: enable, index, data
//   rA, A               software register read: index and combinational data
//   EPC                 copy of register 2 (exception PC)
//   irq_in              interrupt lines, already synchronous to in_CLK
//   pc_in               return PC, captured when the core acknowledges
//   int_req, int_id     request to the core and the interrupt index
//   int_ack, eret       core acknowledge and return-from-handler
//
// Register map: 0 IE (bit 0), 1 MASK, 2 EPC, 3 PEND (write 1 to clear),
// 4 CAUSE (bits 3..0); indices 5..7 read 0 and ignore writes.
//
// Build option: define CP0_IRQ_EDGE_EN for edge-triggered capture (PEND
// latches rising edges until acknowledged or cleared). When it is undefined,
// PEND follows irq_in, sampled every clock, and cannot be cleared by software
// or by an acknowledge.
//
// state     | meaning
// S_IDLE    | no request outstanding; int_id reads 0
// S_REQ     | int_req high, int_id held until int_ack or the request vanishes
// S_SERVICE | handler running; waits for eret to re-enable interrupts

module cp0_intc #(
  parameter int NIRQ = 4,
  parameter int DW   = 32
) (
  input  logic            in_CLK,
  input  logic            in_RST_N,
  input  logic            WE,
  input  logic [2:0]      rW,
  input  logic [DW-1:0]   W,
  input  logic [2:0]      rA,
  output logic [DW-1:0]   A,
  output logic [DW-1:0]   EPC,
  input  logic [NIRQ-1:0] irq_in,
  input  logic [DW-1:0]   pc_in,
  output logic            int_req,
  output logic [3:0]      int_id,
  input  logic            int_ack,
  input  logic            eret
);

  localparam logic [2:0] ADDR_IE    = 3'd0;
  localparam logic [2:0] ADDR_MASK  = 3'd1;
  localparam logic [2:0] ADDR_EPC   = 3'd2;
  localparam logic [2:0] ADDR_PEND  = 3'd3;
  localparam logic [2:0] ADDR_CAUSE = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            ie_q, ie_d;
  logic [NIRQ-1:0] mask_q, mask_d;
  logic [DW-1:0]   epc_q, epc_d;
  logic [NIRQ-1:0] pend_q, pend_d;
  logic [3:0]      cause_q, cause_d;
  logic [3:0]      int_id_q, int_id_d;
`ifdef CP0_IRQ_EDGE_EN
  logic [NIRQ-1:0] irq_prev_q, irq_prev_d;
  logic [NIRQ-1:0] pend_clr;
`endif

  logic [NIRQ-1:0] eff_vec;
  logic [3:0]      sel_id;
  logic            ack_take;
  logic            eret_take;

  assign eff_vec = pend_q & mask_q;

  // Fixed priority: scanning downward leaves the lowest set index in sel_id.
  always_comb begin
    sel_id = 4'd0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (eff_vec[i]) sel_id = 4'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    int_id_d  = int_id_q;
    ack_take  = 1'b0;
    eret_take = 1'b0;
    case (state_q)
      S_IDLE: begin
        int_id_d = 4'd0;
        if (ie_q && (eff_vec != '0)) begin
          state_d  = S_REQ;
          int_id_d = sel_id;
        end
      end
      S_REQ: begin
        // The acknowledge wins over a same-cycle withdrawal: the core has
        // already committed to the id it saw while int_req was high.
        if (int_ack) begin
          ack_take = 1'b1;
          state_d  = S_SERVICE;
        end else if (!ie_q || (eff_vec == '0)) begin
          state_d  = S_IDLE;
          int_id_d = 4'd0;
        end
      end
      S_SERVICE: begin
        if (eret) begin
          eret_take = 1'b1;
          state_d   = S_IDLE;
          int_id_d  = 4'd0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        int_id_d = 4'd0;
      end
    endcase
  end

  // Software writes are applied first so that acknowledge/eret override them.
  always_comb begin
    ie_d    = ie_q;
    mask_d  = mask_q;
    epc_d   = epc_q;
    cause_d = cause_q;

    if (WE) begin
      case (rW)
        ADDR_IE:    ie_d    = W[0];
        ADDR_MASK:  mask_d  = W[NIRQ-1:0];
        ADDR_EPC:   epc_d   = W;
        ADDR_CAUSE: cause_d = W[3:0];
        default:    ;
      endcase
    end

    if (ack_take) begin
      ie_d    = 1'b0;
      epc_d   = pc_in;
      cause_d = int_id_q;
    end else if (eret_take) begin
      ie_d = 1'b1;
    end
  end

`ifdef CP0_IRQ_EDGE_EN
  // A fresh rising edge beats a same-cycle clear so no interrupt is lost.
  always_comb begin
    pend_clr = '0;
    if (WE && (rW == ADDR_PEND)) pend_clr = W[NIRQ-1:0];
    if (ack_take) pend_clr = pend_clr | (NIRQ'(1) << int_id_q);
    irq_prev_d = irq_in;
    pend_d     = (pend_q & ~pend_clr) | (irq_in & ~irq_prev_q);
  end
`else
  always_comb begin
    pend_d = irq_in;
  end
`endif

  always_ff @(posedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N) begin
      state_q    <= S_IDLE;
      ie_q       <= 1'b0;
      mask_q     <= '0;
      epc_q      <= '0;
      pend_q     <= '0;
      cause_q    <= 4'd0;
      int_id_q   <= 4'd0;
`ifdef CP0_IRQ_EDGE_EN
      irq_prev_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      ie_q       <= ie_d;
      mask_q     <= mask_d;
      epc_q      <= epc_d;
      pend_q     <= pend_d;
      cause_q    <= cause_d;
      int_id_q   <= int_id_d;
`ifdef CP0_IRQ_EDGE_EN
      irq_prev_q <= irq_prev_d;
`endif
    end
  end

  always_comb begin
    A = '0;
    case (rA)
      ADDR_IE:    A = DW'(ie_q);
      ADDR_MASK:  A = DW'(mask_q);
      ADDR_EPC:   A = epc_q;
      ADDR_PEND:  A = DW'(pend_q);
      ADDR_CAUSE: A = DW'(cause_q);
      default:    A = '0;
    endcase
  end

  assign EPC     = epc_q;
  assign int_req = (state_q == S_REQ);
  assign int_id  = int_id_q;

endmodule
